// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache request controller: FSM state encoding
// and the geometry of the 4-way cache_memory age vector.
package cache_ctrl_pkg;

  localparam int NUM_WAYS = 4;
  localparam int AGE_W    = 2;
  localparam int WAY_W    = $clog2(NUM_WAYS);

  localparam logic [AGE_W-1:0] AGE_MAX = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_MEM_RD = 3'd3;
  localparam logic [2:0] ST_MEM_WR = 3'd4;
  localparam logic [2:0] ST_FILL   = 3'd5;
  localparam logic [2:0] ST_RESP   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOOKUP = ST_LOOKUP,
    S_CHECK  = ST_CHECK,
    S_MEM_RD = ST_MEM_RD,
    S_MEM_WR = ST_MEM_WR,
    S_FILL   = ST_FILL,
    S_RESP   = ST_RESP
  } state_e;

endpackage

// File: rtl/lru_victim_select.sv
// Picks the least-recently-used way of the addressed set: the lowest-index
// way whose age has reached AGE_MAX, or way 0 when no way qualifies.
module lru_victim_select
  import cache_ctrl_pkg::*;
(
  input  logic [NUM_WAYS*AGE_W-1:0] ages_i,
  output logic [WAY_W-1:0]          victim_way_o
);

  // Priority search; scanning downward lets the lowest matching way win.
  always_comb begin
    victim_way_o = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (ages_i[w*AGE_W +: AGE_W] == AGE_MAX) begin
        victim_way_o = w[WAY_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// CPU-side cache controller: looks requests up in cache_memory, writes
// through to main memory, allocates on read miss, and keeps saturating
// hit/miss statistics. All control outputs are registered.
module cache_ctrl_fsm
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 8,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic                      cpu_ready,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_err,
  output logic [ADDR_W-1:0]         cm_address_word,
  output logic                      cm_try_read,
  output logic                      cm_try_write,
  output logic [DATA_W-1:0]         cm_write_data,
  input  logic [DATA_W-1:0]         cm_data,
  input  logic [NUM_WAYS*AGE_W-1:0] cm_ages,
  input  logic                      cm_hit_miss,
  input  logic [NUM_WAYS-1:0]       cm_hit_miss_set,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [WAY_W-1:0]          victim_way,
  output logic [CNT_W-1:0]          hit_count,
  output logic [CNT_W-1:0]          miss_count
);

  localparam int                TMO_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e              state_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                cpu_ready_q, cpu_err_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [ADDR_W-1:0]   cm_addr_q;
  logic                cm_rd_q, cm_wr_q;
  logic [DATA_W-1:0]   cm_wdata_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;
  logic [CNT_W-1:0]    hit_cnt_d, miss_cnt_d;

  // The hit-way one-hot is informational here; the fill way is chosen by cache_memory.
  logic unused_hit_set;
  assign unused_hit_set = ^cm_hit_miss_set;

  assign hit_cnt_d  = sat_inc(hit_cnt_q);
  assign miss_cnt_d = sat_inc(miss_cnt_q);

  // Request sequencing: each transition also sets the outputs the next state presents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      tmo_q       <= '0;
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      cm_addr_q   <= '0;
      cm_rd_q     <= 1'b0;
      cm_wr_q     <= 1'b0;
      cm_wdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            we_q       <= cpu_we;
            addr_q     <= cpu_addr;
            wdata_q    <= cpu_wdata;
            rdata_q    <= '0;
            cm_addr_q  <= cpu_addr;
            cm_rd_q    <= ~cpu_we;
            cm_wr_q    <= cpu_we;
            cm_wdata_q <= cpu_we ? cpu_wdata : '0;
            state_q    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          cm_rd_q    <= 1'b0;
          cm_wr_q    <= 1'b0;
          cm_wdata_q <= '0;
          state_q    <= S_CHECK;
        end
        S_CHECK: begin
          if (cm_hit_miss) hit_cnt_q  <= hit_cnt_d;
          else             miss_cnt_q <= miss_cnt_d;
          tmo_q <= '0;
          if (we_q || !cm_hit_miss) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= we_q;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= wdata_q;
            state_q     <= we_q ? S_MEM_WR : S_MEM_RD;
          end else begin
            rdata_q     <= cm_data;
            cpu_ready_q <= 1'b1;
            cpu_rdata_q <= cm_data;
            cpu_err_q   <= 1'b0;
            state_q     <= S_RESP;
          end
        end
        S_MEM_RD, S_MEM_WR: begin
          if (mem_ack || tmo_q == TMO_LAST) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end
          if (mem_ack && state_q == S_MEM_RD) begin
            rdata_q    <= mem_rdata;
            cm_wr_q    <= 1'b1;
            cm_wdata_q <= mem_rdata;
            state_q    <= S_FILL;
          end else if (mem_ack) begin
            cpu_ready_q <= 1'b1;
            cpu_rdata_q <= '0;
            cpu_err_q   <= 1'b0;
            state_q     <= S_RESP;
          end else if (tmo_q == TMO_LAST) begin
            cpu_ready_q <= 1'b1;
            cpu_rdata_q <= '0;
            cpu_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_FILL: begin
          cm_wr_q     <= 1'b0;
          cm_wdata_q  <= '0;
          cpu_ready_q <= 1'b1;
          cpu_rdata_q <= rdata_q;
          cpu_err_q   <= 1'b0;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          cpu_ready_q <= 1'b0;
          cpu_rdata_q <= '0;
          cpu_err_q   <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_ready       = cpu_ready_q;
  assign cpu_rdata       = cpu_rdata_q;
  assign cpu_err         = cpu_err_q;
  assign cm_address_word = cm_addr_q;
  assign cm_try_read     = cm_rd_q;
  assign cm_try_write    = cm_wr_q;
  assign cm_write_data   = cm_wdata_q;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign hit_count       = hit_cnt_q;
  assign miss_count      = miss_cnt_q;

  lru_victim_select u_victim (
    .ages_i       (cm_ages),
    .victim_way_o (victim_way)
  );

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: directed scenarios plus randomized transactions
// against a transaction-level reference model of latency, data and counters.
`timescale 1ns/1ps
module tb_cache_ctrl_fsm;

  localparam int MEM_TO = 64;
  localparam int SAT_W  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready, cpu_err;
  logic [7:0]  cpu_rdata;
  logic [31:0] cm_address_word;
  logic        cm_try_read, cm_try_write;
  logic [7:0]  cm_write_data, cm_data, cm_ages;
  logic        cm_hit_miss;
  logic [3:0]  cm_hit_miss_set;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [1:0]  victim_way;
  logic [15:0] hit_count, miss_count;

  logic        sat_unused_ready, sat_unused_err, sat_unused_rd, sat_unused_wr;
  logic        sat_unused_mreq, sat_unused_mwe;
  logic [7:0]  sat_unused_rdata, sat_unused_cmw, sat_unused_mwd;
  logic [31:0] sat_unused_cma, sat_unused_ma;
  logic [1:0]  sat_unused_vw;
  logic [SAT_W-1:0] sat_hit, sat_miss;

  logic [127:0] dut_outs;
  assign dut_outs = {cpu_ready, cpu_rdata, cpu_err, cm_address_word, cm_try_read,
                     cm_try_write, cm_write_data, mem_req, mem_we, mem_addr, mem_wdata,
                     victim_way, hit_count, miss_count};

  int checks = 0;
  int failures = 0;
  int hits_m = 0;
  int misses_m = 0;
  logic [7:0] last_rdata;
  logic       last_err;
  int         last_lat, last_memc;

  always #5 clk = ~clk;

  cache_ctrl_fsm #(.ADDR_W(32), .DATA_W(8), .MEM_TIMEOUT(MEM_TO), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .cm_address_word(cm_address_word), .cm_try_read(cm_try_read), .cm_try_write(cm_try_write),
    .cm_write_data(cm_write_data), .cm_data(cm_data), .cm_ages(cm_ages),
    .cm_hit_miss(cm_hit_miss), .cm_hit_miss_set(cm_hit_miss_set), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .victim_way(victim_way), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  // Narrow-counter twin driven by the same stimulus, so saturation is reachable quickly.
  cache_ctrl_fsm #(.ADDR_W(32), .DATA_W(8), .MEM_TIMEOUT(MEM_TO), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(sat_unused_ready), .cpu_rdata(sat_unused_rdata),
    .cpu_err(sat_unused_err), .cm_address_word(sat_unused_cma), .cm_try_read(sat_unused_rd),
    .cm_try_write(sat_unused_wr), .cm_write_data(sat_unused_cmw), .cm_data(cm_data),
    .cm_ages(cm_ages), .cm_hit_miss(cm_hit_miss), .cm_hit_miss_set(cm_hit_miss_set),
    .mem_req(sat_unused_mreq), .mem_we(sat_unused_mwe), .mem_addr(sat_unused_ma),
    .mem_wdata(sat_unused_mwd), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .victim_way(sat_unused_vw), .hit_count(sat_hit), .miss_count(sat_miss)
  );

  function automatic int sat_lim(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic logic [1:0] victim_model(input logic [7:0] a);
    for (int w = 0; w < 4; w++) begin
      if (a[2*w +: 2] == 2'd3) return w[1:0];
    end
    return 2'd0;
  endfunction

  // One CPU transaction with a responding memory; expectations come from the request rules.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [7:0] wd,
                        input logic hit, input logic [7:0] cd, input int d,
                        input logic [7:0] mrd);
    logic ack_ok, exp_mem, exp_fill, exp_err, done;
    logic [7:0] exp_rd, exp_cmw;
    int exp_memc, exp_lat, exp_rdc, exp_wrc;
    int n, memc, rdc, wrc, bad, both;
    ack_ok   = (d < MEM_TO);
    exp_mem  = we | ~hit;
    exp_memc = !exp_mem ? 0 : (ack_ok ? d + 1 : MEM_TO);
    exp_fill = ~we & ~hit & ack_ok;
    exp_err  = exp_mem & ~ack_ok;
    exp_rd   = (we || exp_err) ? 8'h00 : (hit ? cd : mrd);
    exp_lat  = 4 + exp_memc + (exp_fill ? 1 : 0);
    exp_rdc  = we ? 0 : 1;
    exp_wrc  = (we || exp_fill) ? 1 : 0;
    exp_cmw  = we ? wd : mrd;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    cm_hit_miss = hit; cm_data = cd; mem_ack = 1'b0;
    n = 0; memc = 0; rdc = 0; wrc = 0; bad = 0; both = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      if (cm_try_read && cm_try_write) both++;
      if (cm_try_read) begin
        rdc++;
        if (cm_address_word !== addr) bad++;
      end
      if (cm_try_write) begin
        wrc++;
        if (cm_address_word !== addr || cm_write_data !== exp_cmw) bad++;
      end
      if (mem_req) begin
        if (mem_we !== we || mem_addr !== addr || mem_wdata !== wd) bad++;
        if (memc == d) begin
          mem_ack   = 1'b1;
          mem_rdata = mrd;
        end
        memc++;
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
      end
      if (cpu_ready) begin
        done = 1'b1;
        last_rdata = cpu_rdata;
        last_err   = cpu_err;
        cpu_req    = 1'b0;
      end else begin
        cpu_req   = 1'($urandom);
        cpu_we    = 1'($urandom);
        cpu_addr  = $urandom;
        cpu_wdata = 8'($urandom);
      end
    end
    last_lat  = n + 1;
    last_memc = memc;
    if (hit) hits_m++; else misses_m++;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL txn_done: no cpu_ready after %0d cycles (addr %h)", n, addr);
    end
    checks++;
    if (last_lat != exp_lat) begin
      failures++;
      $display("FAIL latency: got %0d cycles, expected %0d (we=%0b hit=%0b d=%0d)", last_lat, exp_lat, we, hit, d);
    end
    checks++;
    if (last_rdata !== exp_rd) begin
      failures++;
      $display("FAIL rdata: got %h, expected %h", last_rdata, exp_rd);
    end
    checks++;
    if (last_err !== exp_err) begin
      failures++;
      $display("FAIL err: got %b, expected %b", last_err, exp_err);
    end
    checks++;
    if (memc != exp_memc) begin
      failures++;
      $display("FAIL mem_req_cycles: got %0d, expected %0d", memc, exp_memc);
    end
    checks++;
    if (rdc != exp_rdc || wrc != exp_wrc) begin
      failures++;
      $display("FAIL cm_strobes: got rd=%0d wr=%0d, expected rd=%0d wr=%0d", rdc, wrc, exp_rdc, exp_wrc);
    end
    checks++;
    if (bad != 0 || both != 0) begin
      failures++;
      $display("FAIL bus_fields: got %0d bad fields and %0d dual strobes, expected 0 and 0", bad, both);
    end
    checks++;
    if (hit_count !== 16'(sat_lim(hits_m, 16)) || miss_count !== 16'(sat_lim(misses_m, 16))) begin
      failures++;
      $display("FAIL counters: got hit=%0d miss=%0d, expected hit=%0d miss=%0d", hit_count, miss_count, sat_lim(hits_m, 16), sat_lim(misses_m, 16));
    end
    checks++;
    if (sat_hit !== SAT_W'(sat_lim(hits_m, SAT_W)) || sat_miss !== SAT_W'(sat_lim(misses_m, SAT_W))) begin
      failures++;
      $display("FAIL sat_counters: got hit=%0d miss=%0d, expected hit=%0d miss=%0d", sat_hit, sat_miss, sat_lim(hits_m, SAT_W), sat_lim(misses_m, SAT_W));
    end
    @(negedge clk);
    mem_ack = 1'b0;
    cpu_req = 1'b0;
    checks++;
    if (cpu_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_pulse: got cpu_ready=%b one cycle later, expected 0", cpu_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1; cpu_wdata = 8'h1;
    cm_data = 8'h0; cm_ages = 8'h0; cm_hit_miss = 1'b1; cm_hit_miss_set = 4'h1;
    mem_ack = 1'b1; mem_rdata = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_outs !== '0 || sat_hit !== '0 || sat_miss !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, expected all zero", dut_outs);
    end
    rst = 1'b0; cpu_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_hit;
    do_txn(1'b0, 32'h0000_1234, 8'h00, 1'b1, 8'hA5, 0, 8'h00);
    checks++;
    if (last_rdata !== 8'hA5 || last_lat != 4 || last_memc != 0 || hit_count !== 16'd1) begin
      failures++;
      $display("FAIL read_hit: got rdata=%h lat=%0d memc=%0d hits=%0d, expected a5 4 0 1", last_rdata, last_lat, last_memc, hit_count);
    end
  endtask

  task automatic test_read_miss;
    do_txn(1'b0, 32'h0000_2000, 8'h00, 1'b0, 8'h11, 2, 8'h3C);
    checks++;
    if (last_rdata !== 8'h3C || miss_count !== 16'd1) begin
      failures++;
      $display("FAIL read_miss: got rdata=%h misses=%0d, expected 3c 1", last_rdata, miss_count);
    end
  endtask

  task automatic test_write;
    do_txn(1'b1, 32'h0000_0010, 8'h77, 1'b1, 8'h99, 4, 8'hEE);
    checks++;
    if (last_rdata !== 8'h00 || last_err !== 1'b0 || last_memc != 5) begin
      failures++;
      $display("FAIL write_through: got rdata=%h err=%b memc=%0d, expected 00 0 5", last_rdata, last_err, last_memc);
    end
  endtask

  task automatic test_timeout;
    do_txn(1'b0, 32'h0000_3000, 8'h00, 1'b0, 8'h00, MEM_TO + 50, 8'h42);
    checks++;
    if (last_err !== 1'b1 || last_rdata !== 8'h00 || last_memc != 64) begin
      failures++;
      $display("FAIL timeout: got err=%b rdata=%h memc=%0d, expected 1 00 64", last_err, last_rdata, last_memc);
    end
    do_txn(1'b0, 32'h0000_3004, 8'h00, 1'b0, 8'h00, MEM_TO - 1, 8'h24);
  endtask

  task automatic test_victim;
    logic [7:0] a;
    cm_ages = 8'b00_11_01_10;
    #1;
    checks++;
    if (victim_way !== 2'd2) begin
      failures++;
      $display("FAIL victim_fixed: got %0d, expected 2", victim_way);
    end
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      cm_ages = a;
      #1;
      checks++;
      if (victim_way !== victim_model(a)) begin
        failures++;
        $display("FAIL victim_rand: ages=%b got %0d, expected %0d", a, victim_way, victim_model(a));
      end
    end
    cm_ages = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++) begin
      do_txn(1'b0, $urandom, 8'h00, 1'b1, 8'($urandom), 0, 8'h00);
      checks++;
      if (last_lat != 4) begin
        failures++;
        $display("FAIL back_to_back: got latency %0d, expected 4", last_lat);
      end
    end
  endtask

  task automatic test_random;
    int d;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       d = MEM_TO + 5;
        1:       d = $urandom_range(MEM_TO - 3, MEM_TO - 1);
        default: d = $urandom_range(0, 6);
      endcase
      do_txn(($urandom_range(0, 3) == 0), $urandom, 8'($urandom), 1'($urandom),
             8'($urandom), d, 8'($urandom));
    end
  endtask

  task automatic test_reset_mid;
    int k, bad;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_4000; cm_hit_miss = 1'b0; mem_ack = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      cpu_req = 1'b0;
      k++;
    end while (!mem_req && k < 10);
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL reach_mem_rd: got mem_req=%b after %0d cycles, expected 1", mem_req, k);
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_outs !== '0 || sat_hit !== '0 || sat_miss !== '0) begin
      failures++;
      $display("FAIL reset_mid: got %h, expected all zero", dut_outs);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 8'h5A;
    @(negedge clk);
    mem_ack = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if ({cpu_ready, mem_req, cm_try_read, cm_try_write, cpu_rdata, hit_count, miss_count} !== '0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL late_ack: got %0d active cycles after reset, expected 0", bad);
    end
    hits_m = 0;
    misses_m = 0;
    do_txn(1'b0, 32'h0000_5000, 8'h00, 1'b1, 8'hC3, 0, 8'h00);
    checks++;
    if (hit_count !== 16'd1 || miss_count !== 16'd0) begin
      failures++;
      $display("FAIL post_reset_counts: got hit=%0d miss=%0d, expected 1 0", hit_count, miss_count);
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss();
    test_write();
    test_timeout();
    test_victim();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
